// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - fetch push, execute resolve, redirect and predictor-update signals of branch_resolver
interface branch_resolver_if #(
  parameter int IDX_W = 10
);
  logic             f_valid;
  logic [31:0]      f_pc;
  logic             f_pred;
  logic             f_ready;
  logic             r_valid;
  logic             r_taken;
  logic [31:0]      r_target;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             upd_mispredict;

  modport master (
    output f_valid, f_pc, f_pred, r_valid, r_taken, r_target,
    input  f_ready, redirect, redirect_pc, upd_valid, upd_index, upd_taken, upd_mispredict
  );

  modport slave (
    input  f_valid, f_pc, f_pred, r_valid, r_taken, r_target,
    output f_ready, redirect, redirect_pc, upd_valid, upd_index, upd_taken, upd_mispredict
  );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order prediction queue, resolve/mispredict redirect and predictor training.
// Optional resolve/mispredict statistics counters built when BR_RESOLVER_STATS_EN is defined.
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int IDX_W        = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  branch_resolver_if.slave           br,
  output logic [$clog2(DEPTH+1)-1:0] inflight_count,
  output logic                       r_error,
  output logic [31:0]                stat_resolved,
  output logic [31:0]                stat_mispred
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FC_W  = $clog2(FLUSH_CYCLES+1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [FC_W-1:0]  flush_cnt;
  logic [31:0]      pc_mem   [DEPTH];
  logic             pred_mem [DEPTH];

  logic        push;
  logic        pop;
  logic        mispredict;
  logic        empty_resolve;
  logic [31:0] head_pc;
  logic        head_pred;

  // Gated by rstn so every output, f_ready included, reads 0 while reset is held.
  assign br.f_ready    = rstn && (state == RUN) && (inflight_count < CNT_W'(DEPTH));
  assign push          = br.f_valid && br.f_ready;
  assign pop           = br.r_valid && (state == RUN) && (inflight_count != '0);
  assign empty_resolve = br.r_valid && (state == RUN) && (inflight_count == '0);
  assign head_pc       = pc_mem[head];
  assign head_pred     = pred_mem[head];
  assign mispredict    = pop && (head_pred ^ br.r_taken);

  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      pc_mem[tail]   <= br.f_pc;
      pred_mem[tail] <= br.f_pred;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= RUN;
      head              <= '0;
      tail              <= '0;
      inflight_count    <= '0;
      flush_cnt         <= '0;
      r_error           <= 1'b0;
      br.redirect       <= 1'b0;
      br.redirect_pc    <= '0;
      br.upd_valid      <= 1'b0;
      br.upd_index      <= '0;
      br.upd_taken      <= 1'b0;
      br.upd_mispredict <= 1'b0;
    end else begin
      br.redirect  <= 1'b0;
      br.upd_valid <= 1'b0;
      if (empty_resolve) begin
        r_error <= 1'b1;
      end
      if (pop) begin
        br.upd_valid      <= 1'b1;
        br.upd_index      <= head_pc[IDX_W-1:0];
        br.upd_taken      <= br.r_taken;
        br.upd_mispredict <= mispredict;
      end
      unique case (state)
        RUN: begin
          if (mispredict) begin
            // Every younger record is wrong-path, including one pushed this cycle.
            br.redirect    <= 1'b1;
            br.redirect_pc <= br.r_taken ? br.r_target : head_pc + 32'd4;
            head           <= '0;
            tail           <= '0;
            inflight_count <= '0;
            flush_cnt      <= FC_W'(FLUSH_CYCLES);
            state          <= FLUSH;
          end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            unique case ({push, pop})
              2'b10:   inflight_count <= inflight_count + CNT_W'(1);
              2'b01:   inflight_count <= inflight_count - CNT_W'(1);
              default: inflight_count <= inflight_count;
            endcase
          end
        end
        FLUSH: begin
          if (flush_cnt <= FC_W'(1)) begin
            flush_cnt <= '0;
            state     <= RUN;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BR_RESOLVER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && (stat_resolved != 32'hFFFF_FFFF)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (mispredict && (stat_mispred != 32'hFFFF_FFFF)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed and randomized checks of branch_resolver against a queue-based reference model
module tb_branch_resolver;
  localparam int DEPTH        = 4;
  localparam int IDX_W        = 10;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = $clog2(DEPTH+1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if #(.IDX_W(IDX_W)) bif ();
  logic [CNT_W-1:0] inflight_count;
  logic             r_error;
  logic [31:0]      stat_resolved;
  logic [31:0]      stat_mispred;

  branch_resolver #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rstn(rstn), .br(bif),
    .inflight_count(inflight_count), .r_error(r_error),
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    bit          pred;
  } rec_t;

  rec_t             q[$];
  int               flush_left;
  bit               m_err;
  int               m_res;
  int               m_mis;
  logic [IDX_W-1:0] m_idx;
  bit               m_taken;
  bit               m_misflag;
  logic [31:0]      m_rpc;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flush_left = 0;
    m_err      = 0;
    m_res      = 0;
    m_mis      = 0;
    m_idx      = '0;
    m_taken    = 0;
    m_misflag  = 0;
    m_rpc      = '0;
  endtask

  task automatic chk_stats();
`ifdef BR_RESOLVER_STATS_EN
    chk("stat_resolved", stat_resolved, 32'(m_res));
    chk("stat_mispred", stat_mispred, 32'(m_mis));
`else
    chk("stat_resolved", stat_resolved, 32'd0);
    chk("stat_mispred", stat_mispred, 32'd0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_ready"}, 32'(bif.f_ready), 32'd0);
    chk({tag, "_redirect"}, 32'(bif.redirect), 32'd0);
    chk({tag, "_redirect_pc"}, bif.redirect_pc, 32'd0);
    chk({tag, "_upd_valid"}, 32'(bif.upd_valid), 32'd0);
    chk({tag, "_upd_index"}, 32'(bif.upd_index), 32'd0);
    chk({tag, "_upd_taken"}, 32'(bif.upd_taken), 32'd0);
    chk({tag, "_upd_mis"}, 32'(bif.upd_mispredict), 32'd0);
    chk({tag, "_count"}, 32'(inflight_count), 32'd0);
    chk({tag, "_r_error"}, 32'(r_error), 32'd0);
    chk({tag, "_stat_res"}, stat_resolved, 32'd0);
    chk({tag, "_stat_mis"}, stat_mispred, 32'd0);
  endtask

  // One clock: drive, check pre-edge outputs, advance the model, check post-edge outputs.
  task automatic step(input bit fv, input logic [31:0] pc, input bit pred,
                      input bit rv, input bit tk, input logic [31:0] tgt);
    bit   exp_ready;
    bit   push;
    bit   exp_upd;
    bit   exp_redir;
    rec_t h;
    bif.f_valid  = fv;
    bif.f_pc     = pc;
    bif.f_pred   = pred;
    bif.r_valid  = rv;
    bif.r_taken  = tk;
    bif.r_target = tgt;
    #1;
    exp_ready = (flush_left == 0) && (q.size() < DEPTH);
    chk("f_ready", 32'(bif.f_ready), 32'(exp_ready));
    chk("count_pre", 32'(inflight_count), 32'(q.size()));
    push      = fv && exp_ready;
    exp_upd   = 0;
    exp_redir = 0;
    if (flush_left > 0) begin
      flush_left--;
    end else if (rv) begin
      if (q.size() == 0) begin
        m_err = 1;
      end else begin
        h         = q.pop_front();
        exp_upd   = 1;
        m_idx     = h.pc[IDX_W-1:0];
        m_taken   = tk;
        m_misflag = (h.pred != tk);
        m_res++;
        if (m_misflag) begin
          exp_redir  = 1;
          m_rpc      = tk ? tgt : h.pc + 32'd4;
          q.delete();
          push       = 0;
          flush_left = FLUSH_CYCLES;
          m_mis++;
        end
      end
    end
    if (push) q.push_back('{pc, pred});
    @(posedge clk);
    #1;
    chk("upd_valid", 32'(bif.upd_valid), 32'(exp_upd));
    chk("upd_index", 32'(bif.upd_index), 32'(m_idx));
    chk("upd_taken", 32'(bif.upd_taken), 32'(m_taken));
    chk("upd_mispredict", 32'(bif.upd_mispredict), 32'(m_misflag));
    chk("redirect", 32'(bif.redirect), 32'(exp_redir));
    chk("redirect_pc", bif.redirect_pc, m_rpc);
    chk("count", 32'(inflight_count), 32'(q.size()));
    chk("r_error", 32'(r_error), 32'(m_err));
    chk_stats();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 0, 32'd0);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rtg;
    bit          rtk;
    bif.f_valid  = 0;
    bif.f_pc     = '0;
    bif.f_pred   = 0;
    bif.r_valid  = 0;
    bif.r_taken  = 0;
    bif.r_target = '0;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1;

    // Correct prediction: taken, predicted taken.
    step(1, 32'h100, 1, 0, 0, 32'd0);
    step(0, 32'd0, 0, 1, 1, 32'h200);
    chk("tp1_index", 32'(bif.upd_index), 32'h100);
    chk("tp1_redirect", 32'(bif.redirect), 32'd0);

    // Mispredict, actual taken: redirect to target, then two refused cycles.
    step(1, 32'h40, 0, 0, 0, 32'd0);
    step(0, 32'd0, 0, 1, 1, 32'h80);
    chk("tp2_redirect_pc", bif.redirect_pc, 32'h80);
    chk("tp2_upd_mis", 32'(bif.upd_mispredict), 32'd1);
    step(1, 32'h999, 1, 1, 1, 32'h0);
    step(1, 32'h998, 1, 0, 0, 32'h0);
    idle(1);

    // Mispredict, actual not-taken: fall-through, including 32-bit wrap.
    step(1, 32'h40, 1, 0, 0, 32'd0);
    step(0, 32'd0, 0, 1, 0, 32'h1234);
    chk("tp3_redirect_pc", bif.redirect_pc, 32'h44);
    idle(2);
    step(1, 32'hFFFF_FFFC, 1, 0, 0, 32'd0);
    step(0, 32'd0, 0, 1, 0, 32'h0);
    chk("wrap_redirect_pc", bif.redirect_pc, 32'h0);
    idle(2);

    // Full queue refuses a push even with a same-cycle resolve; FIFO order across wrap.
    for (int i = 0; i < 4; i++) step(1, 32'h1000 + 32'(i * 4), i[0], 0, 0, 32'd0);
    chk("full_count", 32'(inflight_count), 32'd4);
    step(1, 32'h2000, 0, 1, q[0].pred, 32'h0);
    chk("full_refused_count", 32'(inflight_count), 32'd3);
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h3000 + 32'(i * 8), i[1], i[0], q[0].pred, 32'h0);
    end
    while (q.size() > 0) step(0, 32'd0, 0, 1, q[0].pred, 32'h0);

    // Mispredict on the head with a simultaneous push: everything discarded.
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), 1, 0, 0, 32'd0);
    step(1, 32'h600, 1, 1, 0, 32'h0);
    chk("flush_count", 32'(inflight_count), 32'd0);
    idle(2);
    step(0, 32'd0, 0, 1, 1, 32'h0);
    chk("empty_r_error", 32'(r_error), 32'd1);

    // Asynchronous reset during FLUSH, while redirect/upd pulses are live.
    for (int i = 0; i < 3; i++) step(1, 32'h700 + 32'(i * 4), 1, 0, 0, 32'd0);
    step(0, 32'd0, 0, 1, 0, 32'h0);
    #2;
    rstn = 0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
    step(0, 32'd0, 0, 0, 0, 32'd0);
    chk("post_reset_f_ready", 32'(bif.f_ready), 32'd1);

    // Randomized traffic, resolves biased toward correct predictions.
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom() & 32'hFFFF_FFFC;
      rtg = $urandom() & 32'hFFFF_FFFC;
      if (q.size() > 0) rtk = ($urandom_range(0, 4) == 0) ? !q[0].pred : q[0].pred;
      else              rtk = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, rpc, 1'($urandom_range(0, 1)),
           (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0),
           rtk, rtg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
